// File: rtl/mem_xfer_unit.sv
// MAR/MDR memory-transfer unit: loads MAR/MDR from the bus and sequences
// RAM reads/writes. Optional macro MEM_RANGE_CHECK_EN adds an upper-MAR range check.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | accepting bus loads and transfer requests
// ST_RD   | mem_rden high, waiting RD_LAT cycles for q
// ST_CAP  | RAM q valid, MDR captures it at the end edge
// ST_WR   | single-cycle write of MDR to RAM[MAR]
module mem_xfer_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              err_clr,
    output logic [DATA_W-1:0] mdr_q,
    output logic [DATA_W-1:0] mar_q,
    output logic              busy,
    output logic              done,
    output logic              err,
`ifdef MEM_RANGE_CHECK_EN
    output logic              err_addr,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("mem_xfer_unit: RD_LAT must be >= 1");
    end

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  mar_d, mdr_d;
    logic               done_q, done_d;
    logic               err_q, err_d, err_set;
`ifdef MEM_RANGE_CHECK_EN
    logic               erra_q, erra_d, erra_set;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        done_d  = 1'b0;
        err_set = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
        erra_set = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (MARin) mar_d = bus_in;
                if (MDRin) mdr_d = bus_in;
                if (rd_req || wr_req) begin
`ifdef MEM_RANGE_CHECK_EN
                    // range is judged on the MAR already held, not a same-cycle load
                    if ((mar_q >> ADDR_W) != '0) begin
                        err_set  = 1'b1;
                        erra_set = 1'b1;
                    end else
`endif
                    if (rd_req) begin
                        state_d = ST_RD;
                        cnt_d   = '0;
                        if (wr_req) err_set = 1'b1;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAP: begin
                mdr_d   = mem_rdata;
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            ST_WR: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && (MARin || MDRin || rd_req || wr_req))
            err_set = 1'b1;

        err_d = err_set | (err_q & ~err_clr);
`ifdef MEM_RANGE_CHECK_EN
        erra_d = erra_set | (erra_q & ~err_clr);
`endif
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            erra_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MEM_RANGE_CHECK_EN
            erra_q  <= erra_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mem_rden  = (state_q == ST_RD);
    assign mem_wren  = (state_q == ST_WR);
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = mar_q[ADDR_W-1:0];
    assign mem_wdata = mdr_q;
`ifdef MEM_RANGE_CHECK_EN
    assign err_addr  = erra_q;
`endif

endmodule
